// File: rtl/psum_ofifo_pkg.sv
// Shared defaults and types for the psum output FIFO bank below the MAC array.
package psum_ofifo_pkg;

    localparam int unsigned PSUM_BW     = 16;
    localparam int unsigned COL         = 8;
    localparam int unsigned OFIFO_DEPTH = 64;

    typedef struct packed {
        logic empty;
        logic full;
        logic ovf;
    } col_status_t;

endpackage

// File: rtl/psum_ofifo_if.sv
// Bus between the bottom MAC row / row consumer and the psum output FIFO bank.
interface psum_ofifo_if
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned col     = COL
);

    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic [col-1:0]         o_ovf;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ovf
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ovf
    );

endinterface

// File: rtl/psum_ofifo_fifo_col.sv
// Single-column psum FIFO: storage, pointers, occupancy count and sticky overflow.
module fifo_col
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] head,
    output col_status_t        status
);

    localparam int unsigned AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [psum_bw-1:0] mem [depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               wr_ok;
    logic               ovf;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Full is judged on the pre-edge count, so a same-cycle pop does not make room.
    assign wr_ok = wr && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr && full) ovf <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem[wr_ptr] <= din;
    end

    assign head         = mem[rd_ptr];
    assign status.empty = empty;
    assign status.full  = full;
    assign status.ovf   = ovf;

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO bank: one FIFO per column, skewed writes, aligned full-row pops.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned col     = COL,
    parameter int unsigned depth   = OFIFO_DEPTH
) (
    input logic            clk,
    input logic            reset,
    psum_ofifo_if.slave    bus
);

    col_status_t            st [col];
    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         ovf;
    logic [psum_bw*col-1:0] head_row;
    logic [psum_bw*col-1:0] out_q;
    logic                   valid;
    logic                   pop;

    for (genvar i = 0; i < col; i++) begin : g_col
        fifo_col #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_col (
            .clk    (clk),
            .reset  (reset),
            .wr     (bus.wr[i]),
            .pop    (pop),
            .din    (bus.in[i*psum_bw +: psum_bw]),
            .head   (head_row[i*psum_bw +: psum_bw]),
            .status (st[i])
        );
        assign empty[i] = st[i].empty;
        assign full[i]  = st[i].full;
        assign ovf[i]   = st[i].ovf;
    end

    // A row is poppable only once the most-skewed column has written it.
    assign valid = ~|empty;
    assign pop   = bus.rd && valid;

    always_ff @(posedge clk) begin
        if (reset)    out_q <= '0;
        else if (pop) out_q <= head_row;
    end

    assign bus.out     = out_q;
    assign bus.o_valid = valid;
    assign bus.o_full  = |full;
    assign bus.o_ovf   = ovf;

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomised scoreboard bench for psum_ofifo against a per-column queue model.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int unsigned BW    = PSUM_BW;
    localparam int unsigned NC    = COL;
    localparam int unsigned DEPTH = OFIFO_DEPTH;

    typedef logic [BW*NC-1:0] row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_ofifo_if #(.psum_bw(BW), .col(NC)) bus ();

    psum_ofifo #(
        .psum_bw (BW),
        .col     (NC),
        .depth   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [BW-1:0]  mq [NC][$];
    row_t           sb [$];
    row_t           exp_out = '0;
    logic [NC-1:0]  exp_ovf = '0;
    row_t           mon_exp;
    int             compared = 0;
    int             mismatched = 0;
    bit             checks_on = 0;

    task automatic chk(input string name, input row_t act, input row_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        for (int c = 0; c < NC; c++)
            if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_full();
        for (int c = 0; c < NC; c++)
            if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Check the state left by the previous edge, then drive and advance the model.
    task automatic cycle(input bit rst, input logic [NC-1:0] w, input row_t d, input bit r);
        bit            pop;
        bit [NC-1:0]   full_pre;
        row_t          row;
        @(negedge clk);
        if (checks_on) begin
            chk("out", bus.out, exp_out);
            chk("o_valid", row_t'(bus.o_valid), row_t'(model_valid()));
            chk("o_full", row_t'(bus.o_full), row_t'(model_full()));
            chk("o_ovf", row_t'(bus.o_ovf), row_t'(exp_ovf));
        end
        reset   = rst;
        bus.wr  = w;
        bus.in  = d;
        bus.rd  = r;
        if (rst) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            exp_ovf = '0;
            exp_out = '0;
        end else begin
            pop = r && model_valid();
            for (int c = 0; c < NC; c++) full_pre[c] = (mq[c].size() == DEPTH);
            if (pop) begin
                for (int c = 0; c < NC; c++) row[c*BW +: BW] = mq[c].pop_front();
                sb.push_back(row);
                exp_out = row;
            end
            for (int c = 0; c < NC; c++) begin
                if (w[c]) begin
                    if (full_pre[c]) exp_ovf[c] = 1'b1;
                    else             mq[c].push_back(d[c*BW +: BW]);
                end
            end
        end
    endtask

    function automatic row_t splat(input logic [BW-1:0] v);
        row_t r;
        for (int c = 0; c < NC; c++) r[c*BW +: BW] = v;
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < NC; c++) r[c*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Monitor: every accepted pop must present the next scoreboard row one cycle later.
    always @(posedge clk) begin
        if (!reset && bus.rd && bus.o_valid) begin
            #1;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pop_unexpected: got %h expected no pop", bus.out);
            end else begin
                mon_exp = sb.pop_front();
                chk("pop_row", bus.out, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        row_t d;
        bus.in = '0;
        bus.wr = '0;
        bus.rd = 1'b0;

        cycle(1, '0, '0, 0);
        cycle(1, '0, '0, 0);
        checks_on = 1;
        cycle(0, '0, '0, 0);

        // skewed diagonal row
        for (int i = 0; i < NC; i++) begin
            d = '0;
            d[i*BW +: BW] = BW'(16'h0100 + i);
            cycle(0, NC'(1) << i, d, 0);
        end
        cycle(0, '0, '0, 1);
        cycle(0, '0, '0, 0);
        cycle(0, '0, '0, 0);
        chk("skew_row", exp_out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                                  16'h0103, 16'h0102, 16'h0101, 16'h0100});

        // overflow on column 0 only
        for (int n = 0; n < DEPTH + 1; n++) begin
            d = '0;
            d[BW-1:0] = BW'(n);
            cycle(0, NC'(1), d, 0);
        end
        cycle(0, '0, '0, 1);
        cycle(0, '0, '0, 0);
        cycle(1, '0, '0, 0);
        cycle(0, '0, '0, 0);

        // concurrent read/write with counts held at 1, through pointer wrap
        cycle(0, '1, splat(BW'(0)), 0);
        for (int k = 1; k <= 100; k++) cycle(0, '1, splat(BW'(k)), 1);
        cycle(0, '0, '0, 1);
        cycle(0, '0, '0, 0);

        // idle reads on an empty bank
        for (int k = 0; k < 5; k++) cycle(0, '0, '0, 1);
        for (int k = 0; k < 3; k++) cycle(0, '1, rand_row(), 0);
        for (int k = 0; k < 4; k++) cycle(0, '0, '0, 1);

        // randomised skewed traffic
        for (int k = 0; k < 500; k++) begin
            logic [NC-1:0] w;
            w = NC'($urandom) | NC'($urandom);
            cycle(0, w, rand_row(), ($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < DEPTH + 4; k++) cycle(0, '0, '0, 1);

        // reset mid-stream drops queued rows
        for (int k = 0; k < 10; k++) cycle(0, '1, rand_row(), 0);
        cycle(1, '0, '0, 0);
        cycle(0, '0, '0, 1);
        cycle(0, '1, splat(16'hBEEF), 0);
        cycle(0, '0, '0, 1);
        cycle(0, '0, '0, 0);
        chk("beef_row", exp_out, splat(16'hBEEF));
        cycle(0, '0, '0, 0);

        chk("sb_drained", row_t'(sb.size()), row_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
